// File: rtl/conv_enc_frame_ctrl_if.sv
// Signal bundle between the frame source, the frame controller, the convolutional encoder and the code-word consumer.
// Frame and out channels: a word moves on a rising edge where valid and ready are both high; valid holds its payload stable until then.
interface conv_enc_frame_ctrl_if #(
    parameter int FRAME_BITS = 8,
    parameter int MAX_TAIL   = 6
);
    localparam int CODE_W = 2 * (FRAME_BITS + MAX_TAIL);
    localparam int LEN_W  = $clog2(FRAME_BITS + MAX_TAIL + 1);

    logic                  frame_valid;
    logic                  frame_ready;
    logic [FRAME_BITS-1:0] frame_data;
    logic [1:0]            frame_k_sel;
    logic                  frame_flush;

    logic                  enc_clear;
    logic [1:0]            enc_constraint_sel;
    logic                  enc_data_in;
    logic                  enc_in_enable;
    logic                  enc_out_enable;
    logic                  enc_out0;
    logic                  enc_out1;

    logic                  out_valid;
    logic                  out_ready;
    logic [CODE_W-1:0]     out_code;
    logic [LEN_W-1:0]      out_len;
    logic                  out_err;

    modport slave (
        input  frame_valid, frame_data, frame_k_sel, frame_flush,
        input  enc_out_enable, enc_out0, enc_out1,
        input  out_ready,
        output frame_ready, enc_clear, enc_constraint_sel, enc_data_in, enc_in_enable,
        output out_valid, out_code, out_len, out_err
    );

    modport master (
        output frame_valid, frame_data, frame_k_sel, frame_flush,
        output enc_out_enable, enc_out0, enc_out1,
        output out_ready,
        input  frame_ready, enc_clear, enc_constraint_sel, enc_data_in, enc_in_enable,
        input  out_valid, out_code, out_len, out_err
    );
endinterface

// File: rtl/conv_enc_frame_ctrl.sv
// Frame sequencer for the convolutional encoder: clears it, feeds one bit per strobe MSB first,
// packs the returned (out1,out0) pairs into one code word and optionally appends a zero tail.
module conv_enc_frame_ctrl #(
    parameter int FRAME_BITS = 8,
    parameter int MAX_TAIL   = 6,
    parameter int TIMEOUT    = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    conv_enc_frame_ctrl_if.slave bus,
    output logic [2:0]           dbg_state
);
    localparam int TOTAL_MAX = FRAME_BITS + MAX_TAIL;
    localparam int CODE_W    = 2 * TOTAL_MAX;
    localparam int LEN_W     = $clog2(TOTAL_MAX + 1);
    localparam int WCNT_W    = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                state;
    logic [FRAME_BITS-1:0] shreg;
    logic [LEN_W-1:0]      total;
    logic [WCNT_W-1:0]     wait_cnt;
    logic                  frame_ready_q;
    logic                  enc_clear_q;
    logic [1:0]            ksel_q;
    logic                  data_in_q;
    logic                  in_en_q;
    logic                  out_valid_q;
    logic [CODE_W-1:0]     code_q;
    logic [LEN_W-1:0]      len_q;
    logic                  err_q;

    // Tail length that flushes the trellis back to the all-zero state for each constraint length.
    function automatic logic [LEN_W-1:0] tail_len(input logic [1:0] k_sel, input logic flush);
        logic [LEN_W-1:0] t;
        case (k_sel)
            2'b00:   t = LEN_W'(2);
            2'b01:   t = LEN_W'(3);
            2'b10:   t = LEN_W'(4);
            default: t = LEN_W'(6);
        endcase
        return flush ? t : '0;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            shreg         <= '0;
            total         <= '0;
            wait_cnt      <= '0;
            frame_ready_q <= 1'b1;
            enc_clear_q   <= 1'b0;
            ksel_q        <= 2'b00;
            data_in_q     <= 1'b0;
            in_en_q       <= 1'b0;
            out_valid_q   <= 1'b0;
            code_q        <= '0;
            len_q         <= '0;
            err_q         <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.frame_valid) begin
                        shreg         <= bus.frame_data;
                        ksel_q        <= bus.frame_k_sel;
                        total         <= LEN_W'(FRAME_BITS) + tail_len(bus.frame_k_sel, bus.frame_flush);
                        code_q        <= '0;
                        len_q         <= '0;
                        err_q         <= 1'b0;
                        frame_ready_q <= 1'b0;
                        enc_clear_q   <= 1'b1;
                        state         <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    enc_clear_q <= 1'b0;
                    in_en_q     <= 1'b1;
                    data_in_q   <= shreg[FRAME_BITS-1];
                    shreg       <= shreg << 1;
                    state       <= S_ISSUE;
                end
                S_ISSUE: begin
                    in_en_q  <= 1'b0;
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.enc_out_enable) begin
                        code_q <= {code_q[CODE_W-3:0], bus.enc_out1, bus.enc_out0};
                        len_q  <= len_q + LEN_W'(1);
                        if (len_q + LEN_W'(1) == total) begin
                            out_valid_q <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            // Zeros shift in behind the payload, so the tail bits come out for free.
                            in_en_q   <= 1'b1;
                            data_in_q <= shreg[FRAME_BITS-1];
                            shreg     <= shreg << 1;
                            state     <= S_ISSUE;
                        end
                    end else if (wait_cnt == WCNT_W'(TIMEOUT - 1)) begin
                        err_q       <= 1'b1;
                        out_valid_q <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + WCNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q   <= 1'b0;
                        frame_ready_q <= 1'b1;
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.frame_ready        = frame_ready_q;
    assign bus.enc_clear          = enc_clear_q;
    assign bus.enc_constraint_sel = ksel_q;
    assign bus.enc_data_in        = data_in_q;
    assign bus.enc_in_enable      = in_en_q;
    assign bus.out_valid          = out_valid_q;
    assign bus.out_code           = code_q;
    assign bus.out_len            = len_q;
    assign bus.out_err            = err_q;
    assign dbg_state              = state;
endmodule

// File: tb/tb_conv_enc_frame_ctrl.sv
// Bench for conv_enc_frame_ctrl: behavioural encoder with programmable response delay,
// scoreboard of expected code words, and directed plus random frames.
module tb_conv_enc_frame_ctrl;
    localparam int FRAME_BITS = 8;
    localparam int MAX_TAIL   = 6;
    localparam int TIMEOUT    = 15;
    localparam int CODE_W     = 2 * (FRAME_BITS + MAX_TAIL);
    localparam int LEN_W      = $clog2(FRAME_BITS + MAX_TAIL + 1);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] dbg_state;
    int         n_checks = 0;
    int         n_errors = 0;

    conv_enc_frame_ctrl_if #(.FRAME_BITS(FRAME_BITS), .MAX_TAIL(MAX_TAIL)) bus ();

    conv_enc_frame_ctrl #(.FRAME_BITS(FRAME_BITS), .MAX_TAIL(MAX_TAIL), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst_n),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Generator taps {g1, g0}; bit d of each selects the input d steps back.
    function automatic logic [13:0] gen_taps(input logic [1:0] k);
        logic [13:0] g;
        case (k)
            2'd0:    g = {7'b0000101, 7'b0000111};
            2'd1:    g = {7'b0001111, 7'b0001011};
            2'd2:    g = {7'b0011111, 7'b0011011};
            default: g = {7'b1110101, 7'b1001111};
        endcase
        return g;
    endfunction

    function automatic int tail_of(input logic [1:0] k, input bit flush);
        int t;
        case (k)
            2'd0:    t = 2;
            2'd1:    t = 3;
            2'd2:    t = 4;
            default: t = 6;
        endcase
        return flush ? t : 0;
    endfunction

    function automatic logic [CODE_W-1:0] model_code(input logic [7:0] data, input logic [1:0] k, input bit flush);
        logic [13:0]       g;
        logic [6:0]        h;
        logic [CODE_W-1:0] c;
        logic              b;
        int                n;
        g = gen_taps(k);
        h = '0;
        c = '0;
        n = FRAME_BITS + tail_of(k, flush);
        for (int i = 0; i < n; i++) begin
            b = (i < FRAME_BITS) ? data[FRAME_BITS-1-i] : 1'b0;
            h = {h[5:0], b};
            c = {c[CODE_W-3:0], ^(h & g[13:7]), ^(h & g[6:0])};
        end
        return c;
    endfunction

    // Encoder model: answers dly cycles into WAIT, never when muted; noise pokes out_enable outside WAIT.
    int         cfg_dly = 0;
    bit         cfg_mute = 1'b0;
    bit         cfg_noise = 1'b0;
    int         cur_dly;
    bit         cur_mute;
    logic [6:0] hist;
    logic       pend;
    int         dly;
    logic [13:0] cur_g;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '0; pend <= 1'b0; dly <= 0; cur_dly <= 0; cur_mute <= 1'b0;
        end else if (bus.enc_clear) begin
            hist <= '0; pend <= 1'b0; cur_dly <= cfg_dly; cur_mute <= cfg_mute;
        end else if (bus.enc_in_enable) begin
            hist <= {hist[5:0], bus.enc_data_in}; pend <= 1'b1; dly <= cur_dly;
        end else if (pend) begin
            if (dly == 0) pend <= 1'b0;
            else dly <= dly - 1;
        end
    end

    assign cur_g              = gen_taps(bus.enc_constraint_sel);
    assign bus.enc_out0       = ^(hist & cur_g[6:0]);
    assign bus.enc_out1       = ^(hist & cur_g[13:7]);
    assign bus.enc_out_enable = (pend && dly == 0 && !cur_mute) ||
                                (cfg_noise && (bus.enc_clear || bus.enc_in_enable));

    logic [CODE_W-1:0] exp_q[$];
    int                exp_len_q[$];
    int                exp_err_q[$];
    int                exp_lat_q[$];
    int                exp_nin_q[$];

    int                ready_hold = 0;
    int                done_cyc = 0;
    logic [CODE_W-1:0] last_code;
    int                last_len, last_err, last_nin, last_nclr;

    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk); #2;
            if (!bus.out_valid) begin
                done_cyc = 0;
                bus.out_ready = 1'b0;
            end else begin
                bus.out_ready = (done_cyc >= ready_hold);
                done_cyc++;
            end
        end
    end

    int lat, nin, nclr;
    bit acc_active, prev_valid;

    always @(negedge clk) begin
        if (!rst_n) begin
            acc_active = 1'b0; prev_valid = 1'b0; lat = 0; nin = 0; nclr = 0;
        end else begin
            if (bus.enc_in_enable) nin++;
            if (bus.enc_clear) nclr++;
            if (acc_active) lat++;
            if (bus.frame_valid && bus.frame_ready) begin
                acc_active = 1'b1; lat = 0; nin = 0; nclr = 0;
            end
            if (bus.out_valid) begin
                check("ready_in_done", bus.frame_ready, 1'b0);
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 1'b1, 1'b0);
                end else begin
                    check("code_hold", bus.out_code, exp_q[0]);
                    if (!prev_valid && exp_lat_q[0] >= 0) check("latency", lat, exp_lat_q[0]);
                    if (bus.out_ready) begin
                        check("code", bus.out_code, exp_q.pop_front());
                        check("len", bus.out_len, exp_len_q.pop_front());
                        check("err", bus.out_err, exp_err_q.pop_front());
                        check("n_in_enable", nin, exp_nin_q.pop_front());
                        check("n_clear", nclr, 1);
                        void'(exp_lat_q.pop_front());
                        last_code = bus.out_code; last_len = bus.out_len;
                        last_err = bus.out_err; last_nin = nin; last_nclr = nclr;
                        acc_active = 1'b0;
                    end
                end
            end
            prev_valid = bus.out_valid && !bus.out_ready;
        end
    end

    task automatic send_frame(input logic [7:0] data, input logic [1:0] k, input bit flush,
                              input int rdly, input bit mute, input bit noise);
        int n;
        int guard;
        n = FRAME_BITS + tail_of(k, flush);
        exp_q.push_back(mute ? '0 : model_code(data, k, flush));
        exp_len_q.push_back(mute ? 0 : n);
        exp_err_q.push_back(mute ? 1 : 0);
        exp_lat_q.push_back(mute ? 3 + TIMEOUT : (rdly == 0 ? 2 + 2 * n : -1));
        exp_nin_q.push_back(mute ? 1 : n);
        cfg_dly = rdly; cfg_mute = mute; cfg_noise = noise;
        bus.frame_data = data; bus.frame_k_sel = k; bus.frame_flush = flush; bus.frame_valid = 1'b1;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!bus.frame_ready && guard < 2000);
        if (!bus.frame_ready) check("accept_timeout", 1'b0, 1'b1);
        @(posedge clk); #2;
        bus.frame_valid = 1'b0;
        bus.frame_data = 8'($urandom_range(255, 0));
        @(posedge clk); #2;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check("drain_timeout", exp_q.size(), 0);
        @(posedge clk); #2;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_frame_ready"}, bus.frame_ready, 1'b1);
        check({tag, "_enc_clear"}, bus.enc_clear, 1'b0);
        check({tag, "_in_enable"}, bus.enc_in_enable, 1'b0);
        check({tag, "_data_in"}, bus.enc_data_in, 1'b0);
        check({tag, "_ksel"}, bus.enc_constraint_sel, 2'b00);
        check({tag, "_out_valid"}, bus.out_valid, 1'b0);
        check({tag, "_out_code"}, bus.out_code, '0);
        check({tag, "_out_len"}, bus.out_len, '0);
        check({tag, "_out_err"}, bus.out_err, 1'b0);
    endtask

    initial begin
        int guard;
        bus.frame_valid = 1'b0; bus.frame_data = '0; bus.frame_k_sel = 2'b00; bus.frame_flush = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #2;

        send_frame(8'hAA, 2'd0, 1'b0, 0, 1'b0, 1'b0);
        drain();
        check("t1_code", last_code[15:0], 16'b1101000100010001);
        check("t1_len", last_len, 8);
        check("t1_err", last_err, 0);

        send_frame(8'hAA, 2'd3, 1'b0, 0, 1'b0, 1'b0);
        drain();
        check("t2_k7", last_code[15:0], 16'b1101000010100110);
        send_frame(8'hAA, 2'd1, 1'b0, 0, 1'b0, 1'b0);
        drain();
        check("t2_k4", last_code[15:0], 16'b1111010001000100);
        send_frame(8'hAA, 2'd2, 1'b0, 0, 1'b0, 1'b0);
        drain();
        check("t2_k5", last_code[15:0], 16'b1111010010001000);

        send_frame(8'hAA, 2'd0, 1'b1, 0, 1'b0, 1'b1);
        drain();
        check("t3_code", last_code[19:0], 20'hD111C);
        check("t3_len", last_len, 10);
        check("t3_nin", last_nin, 10);
        check("t3_nclr", last_nclr, 1);

        send_frame(8'h5C, 2'd1, 1'b0, 0, 1'b1, 1'b0);
        drain();
        check("t4_err", last_err, 1);
        check("t4_len", last_len, 0);

        // Second frame is offered while the first sits stalled in DONE.
        ready_hold = 5;
        send_frame(8'h3B, 2'd2, 1'b1, 0, 1'b0, 1'b0);
        send_frame(8'hC4, 2'd3, 1'b1, 1, 1'b0, 1'b0);
        drain();
        ready_hold = 0;

        for (int i = 0; i < 12; i++) begin
            ready_hold = $urandom_range(2, 0);
            send_frame(8'($urandom_range(255, 0)), 2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
                       $urandom_range(3, 0), 1'b0, 1'($urandom_range(1, 0)));
        end
        drain();
        ready_hold = 0;

        send_frame(8'hAA, 2'd3, 1'b1, 2, 1'b0, 1'b0);
        guard = 0;
        while (!(nin == 4 && dbg_state == 3'd3) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("t6_reach_bit4", guard < 200, 1'b1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midreset");
        void'(exp_q.pop_back()); void'(exp_len_q.pop_back()); void'(exp_err_q.pop_back());
        void'(exp_lat_q.pop_back()); void'(exp_nin_q.pop_back());
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
        send_frame(8'hAA, 2'd0, 1'b0, 0, 1'b0, 1'b0);
        drain();
        check("t6_code", last_code, 28'h000D111);
        check("t6_len", last_len, 8);
        check("t6_err", last_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
